conv_window_sequencer: RTL and testbench

Control-and-feed block that drives the convolution datapath's input side. It reads a single-channel image from a synchronous pixel memory and assembles each 4x4 stride-1 window into the 128-bit operand register. It sequences the multiplier and adder-tree stage enables, then captures the datapath's registered `conv_out` into a result memory write port. It sits between the pixel buffer and result buffer on one side and the datapath on the other, and shares the datapath's `clk`/`reset`.

---
 rtl/conv_window_sequencer.sv | 124 ++++++++++++
 tb/tb_conv_window_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Feeds the convolution datapath: gathers each 4x4 stride-1 window from the pixel
// memory, steps the multiplier/adder-tree enables, and writes conv_out to the result memory.
module conv_window_sequencer #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int PIX_AW = 6,
   parameter int RES_AW = 5,
   parameter int ACC_W  = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [127:0]      filter_in,
   output logic              busy,
   output logic              done,
   output logic [PIX_AW-1:0] pix_addr,
   input  logic [7:0]        pix_rdata,
   output logic [127:0]      input_matrix_reg,
   output logic [127:0]      filter_matrix_reg,
   output logic              mul_enable,
   output logic              l1_add_enable,
   output logic              l2_add_enable,
   output logic              l3_add_enable,
   output logic              l4_add_enable,
   input  logic [ACC_W-1:0]  conv_out,
   output logic              res_we,
   output logic [RES_AW-1:0] res_addr,
   output logic [ACC_W-1:0]  res_data
);
   localparam int OW = IMG_W - 3;
   localparam int OH = IMG_H - 3;

   typedef enum logic [3:0] {
      IDLE, FETCH, LOAD, MUL, L1, L2, L3, L4, WAIT, WRITE, DONE
   } state_t;

   state_t            state, state_next;
   logic [3:0]        fetch_k;
   logic [PIX_AW-1:0] orow, ocol;
   logic [PIX_AW-1:0] row_sel, col_sel, lin_idx;
   logic              last_win;

   // Element k of the current window sits at row k/4, column k%4 from the window origin.
   assign row_sel  = orow + PIX_AW'(fetch_k[3:2]);
   assign col_sel  = ocol + PIX_AW'(fetch_k[1:0]);
   assign pix_addr = row_sel * PIX_AW'(IMG_W) + col_sel;

   assign lin_idx  = orow * PIX_AW'(OW) + ocol;
   assign last_win = (orow == PIX_AW'(OH - 1)) && (ocol == PIX_AW'(OW - 1));
   assign res_addr = (state == WRITE) ? RES_AW'(lin_idx) : '0;
   assign res_data = (state == WRITE) ? conv_out : '0;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next    = state;
      busy          = 1'b1;
      done          = 1'b0;
      mul_enable    = 1'b0;
      l1_add_enable = 1'b0;
      l2_add_enable = 1'b0;
      l3_add_enable = 1'b0;
      l4_add_enable = 1'b0;
      res_we        = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = FETCH;
         end
         FETCH: if (fetch_k == 4'd15) state_next = LOAD;
         LOAD:  state_next = MUL;
         MUL:   begin mul_enable    = 1'b1; state_next = L1;   end
         L1:    begin l1_add_enable = 1'b1; state_next = L2;   end
         L2:    begin l2_add_enable = 1'b1; state_next = L3;   end
         L3:    begin l3_add_enable = 1'b1; state_next = L4;   end
         L4:    begin l4_add_enable = 1'b1; state_next = WAIT; end
         WAIT:  state_next = WRITE;
         WRITE: begin
            res_we     = 1'b1;
            state_next = last_win ? DONE : FETCH;
         end
         DONE:  begin done = 1'b1; state_next = IDLE; end
         default: state_next = IDLE;
      endcase
   end

   // Read data lags the address by one cycle, so fetch cycle k lands byte k-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         filter_matrix_reg <= '0;
         input_matrix_reg  <= '0;
         fetch_k           <= '0;
         orow              <= '0;
         ocol              <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               filter_matrix_reg <= filter_in;
               fetch_k           <= '0;
               orow              <= '0;
               ocol              <= '0;
            end
            FETCH: begin
               fetch_k <= fetch_k + 4'd1;
               if (fetch_k != 4'd0)
                  input_matrix_reg[{fetch_k - 4'd1, 3'b000} +: 8] <= pix_rdata;
            end
            LOAD: input_matrix_reg[127:120] <= pix_rdata;
            WRITE: if (!last_win) begin
               if (ocol == PIX_AW'(OW - 1)) begin
                  ocol <= '0;
                  orow <= orow + PIX_AW'(1);
               end else begin
                  ocol <= ocol + PIX_AW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: pixel memory, simple datapath model, and a
// reference model that computes every window result straight from the image.
module tb_conv_window_sequencer;
   localparam int IMG_W  = 8;
   localparam int IMG_H  = 8;
   localparam int PIX_AW = 6;
   localparam int RES_AW = 5;
   localparam int ACC_W  = 20;
   localparam int OW     = IMG_W - 3;
   localparam int OH     = IMG_H - 3;
   localparam int NWIN   = OW * OH;
   localparam int RUN_CYC = 24 * NWIN;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [127:0]      filter_in;
   logic              busy, done;
   logic [PIX_AW-1:0] pix_addr;
   logic [7:0]        pix_rdata;
   logic [127:0]      input_matrix_reg, filter_matrix_reg;
   logic              mul_enable, l1_add_enable, l2_add_enable, l3_add_enable, l4_add_enable;
   logic [ACC_W-1:0]  conv_out;
   logic              res_we;
   logic [RES_AW-1:0] res_addr;
   logic [ACC_W-1:0]  res_data;

   conv_window_sequencer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_AW(PIX_AW), .RES_AW(RES_AW), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .filter_in(filter_in),
      .busy(busy), .done(done), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
      .input_matrix_reg(input_matrix_reg), .filter_matrix_reg(filter_matrix_reg),
      .mul_enable(mul_enable), .l1_add_enable(l1_add_enable), .l2_add_enable(l2_add_enable),
      .l3_add_enable(l3_add_enable), .l4_add_enable(l4_add_enable),
      .conv_out(conv_out), .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
   );

   // clock / reset
   always #5 clk = ~clk;

   // pixel memory (one-cycle read latency) and datapath stand-in
   logic [7:0]       pix_mem [0:IMG_W*IMG_H-1];
   logic [ACC_W-1:0] dp_sum;
   logic             dp_wait;

   function automatic logic [ACC_W-1:0] dot16(input logic [127:0] a, input logic [127:0] b);
      int s = 0;
      for (int k = 0; k < 16; k++) s += int'(a[8*k +: 8]) * int'(b[8*k +: 8]);
      return ACC_W'(s);
   endfunction

   always @(posedge clk) pix_rdata <= pix_mem[pix_addr];

   always @(posedge clk) begin
      if (!reset) begin
         dp_sum   <= '0;
         dp_wait  <= 1'b0;
         conv_out <= '0;
      end else begin
         if (mul_enable) dp_sum <= dot16(input_matrix_reg, filter_matrix_reg);
         dp_wait <= l4_add_enable;
         if (dp_wait) conv_out <= dp_sum;
      end
   end

   // reference model
   function automatic logic [127:0] win_ref(input int orow, input int ocol);
      logic [127:0] w;
      for (int k = 0; k < 16; k++) w[8*k +: 8] = pix_mem[(orow + k / 4) * IMG_W + ocol + k % 4];
      return w;
   endfunction

   function automatic logic [ACC_W-1:0] conv_ref(input int orow, input int ocol, input logic [127:0] f);
      int s = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s += int'(pix_mem[(orow + r) * IMG_W + ocol + c]) * int'(f[8 * (4 * r + c) +: 8]);
      return ACC_W'(s);
   endfunction

   // scoreboard
   logic [RES_AW+ACC_W-1:0] exp_q[$];
   logic [127:0]            exp_filter;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_on = 1'b0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
      end
   endtask

   // per-cycle monitor: cyc is the cycle index within the current run
   initial begin : monitor
      int ph, win, orw, ocl;
      bit in_run;
      logic [RES_AW+ACC_W-1:0] e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            in_run = (cyc < RUN_CYC);
            ph  = cyc % 24;
            win = cyc / 24;
            orw = win / OW;
            ocl = win % OW;
            check_val("busy", busy, cyc <= RUN_CYC);
            check_val("done", done, cyc == RUN_CYC);
            check_val("mul_en", mul_enable, in_run && ph == 17);
            check_val("l1_en", l1_add_enable, in_run && ph == 18);
            check_val("l2_en", l2_add_enable, in_run && ph == 19);
            check_val("l3_en", l3_add_enable, in_run && ph == 20);
            check_val("l4_en", l4_add_enable, in_run && ph == 21);
            check_val("res_we", res_we, in_run && ph == 23);
            check_val("filter_reg", filter_matrix_reg, exp_filter);
            if (in_run && ph < 16)
               check_val("pix_addr", pix_addr, (orw + ph / 4) * IMG_W + ocl + ph % 4);
            if (in_run && ph == 17)
               check_val("window", input_matrix_reg, win_ref(orw, ocl));
            if (in_run && ph == 23 && res_we) begin
               if (exp_q.size() == 0) check_val("exp_q_empty", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check_val("res_addr", res_addr, e[RES_AW+ACC_W-1:ACC_W]);
                  check_val("res_data", res_data, e[ACC_W-1:0]);
               end
            end
         end
         cyc = cyc + 1;
      end
   end

   // driver tasks
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cyc < n) check_val("wait_timeout", cyc, n);
   endtask

   // in_done: caller is already inside the DONE cycle, so start must ride through it
   task automatic start_run(input logic [127:0] f, input bit in_done);
      if (!in_done) begin
         @(posedge clk);
         #1;
      end
      start     = 1'b1;
      filter_in = f;
      for (int r = 0; r < OH; r++)
         for (int c = 0; c < OW; c++)
            exp_q.push_back({RES_AW'(r * OW + c), conv_ref(r, c, f)});
      if (in_done) @(posedge clk);
      @(posedge clk);
      #1;
      start      = 1'b0;
      filter_in  = rand128();
      exp_filter = f;
      cyc        = 0;
      mon_on     = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_en"}, {mul_enable, l1_add_enable, l2_add_enable, l3_add_enable, l4_add_enable}, 0);
      check_val({tag, "_we"}, res_we, 0);
      check_val({tag, "_pix_addr"}, pix_addr, 0);
      check_val({tag, "_res_addr"}, res_addr, 0);
      check_val({tag, "_res_data"}, res_data, 0);
      check_val({tag, "_input"}, input_matrix_reg, 0);
      check_val({tag, "_filter"}, filter_matrix_reg, 0);
   endtask

   initial begin
      logic [127:0] f;
      reset     = 1'b0;
      start     = 1'b0;
      filter_in = '0;
      exp_filter = '0;
      for (int i = 0; i < IMG_W * IMG_H; i++) pix_mem[i] = 8'd1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("rst");
      reset = 1'b1;

      // all-ones image and filter, with an ignored start at cycle 50
      f = '0;
      for (int k = 0; k < 16; k++) f[8*k +: 8] = 8'd1;
      start_run(f, 1'b0);
      wait_cyc(50);
      start     = 1'b1;
      filter_in = {16{8'd3}};
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_cyc(RUN_CYC);

      // back-to-back: start raised in DONE, accepted in the following IDLE cycle
      f = '0;
      for (int k = 0; k < 16; k++) f[8*k +: 8] = 8'd2;
      start_run(f, 1'b1);
      wait_cyc(RUN_CYC + 4);

      // ramp image, one-hot filter at k=0
      for (int i = 0; i < IMG_W * IMG_H; i++) pix_mem[i] = 8'(i);
      f = '0;
      f[7:0] = 8'd1;
      start_run(f, 1'b0);
      wait_cyc(RUN_CYC + 3);

      // random image and filter, aborted by reset at cycle 100
      for (int i = 0; i < IMG_W * IMG_H; i++) pix_mem[i] = 8'($urandom_range(0, 255));
      start_run(rand128(), 1'b0);
      wait_cyc(100);
      reset  = 1'b0;
      mon_on = 1'b0;
      @(posedge clk);
      #1;
      check_all_zero("abort");
      check_val("abort_writes_left", exp_q.size(), NWIN - 4);
      exp_q.delete();
      exp_filter = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         check_val("post_abort", {busy, done, res_we}, 0);
      end

      // fresh random run after the abort
      for (int i = 0; i < IMG_W * IMG_H; i++) pix_mem[i] = 8'($urandom_range(0, 255));
      start_run(rand128(), 1'b0);
      wait_cyc(RUN_CYC + 3);

      check_val("exp_q_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
